// File: rtl/data_bus.sv
// Data-side responder: word RAM, LED register and a UART transmitter fed by a byte FIFO.
// Latency: loads are combinational (0 cycles); stores commit at the edge ending the we cycle.
// Backpressure: none toward the core; a TXDATA push into a full FIFO is dropped and sets sticky overflow.
module data_bus #(
    parameter int RAM_WORDS    = 256,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic        uart_tx,
    output logic [7:0]  led
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [31:0] ADDR_TXDATA = 32'h8000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
    localparam logic [31:0] ADDR_LED    = 32'h8000_0008;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

    // Storage arrays (not reset)
    logic [31:0] ram_mem  [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    // Registered state
    tx_state_t   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0] count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  led_q, led_d;

    // Decode and FIFO handshake terms
    logic          sel_ram, sel_txdata, sel_status, sel_led;
    logic [AW-1:0] ram_idx;
    logic          fifo_full, push_req, push_ok, pop, busy, baud_last;
    logic [7:0]    count8;

    assign sel_ram    = ~dataAddr[31];
    assign sel_txdata = (dataAddr == ADDR_TXDATA);
    assign sel_status = (dataAddr == ADDR_STATUS);
    assign sel_led    = (dataAddr == ADDR_LED);
    assign ram_idx    = dataAddr[AW+1:2];

    assign fifo_full = (count_q == (PW+1)'(FIFO_DEPTH));
    assign push_req  = we & sel_txdata;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign pop       = (state_q == ST_IDLE) && (count_q != '0);
    assign push_ok   = push_req & (~fifo_full | pop);
    assign busy      = (state_q != ST_IDLE) || (count_q != '0);
    assign baud_last = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign count8    = 8'(count_q);

    // RAM and FIFO array writes; writes during reset are discarded
    always_ff @(posedge clk) begin
        if (n_reset && we && sel_ram) begin
            ram_mem[ram_idx] <= writeData;
        end
        if (n_reset && push_ok) begin
            fifo_mem[wr_ptr_q] <= writeData[7:0];
        end
    end

    // FIFO pointers, count, sticky overflow and LED register next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        led_d    = led_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        if (we && sel_status) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (we && sel_led) begin
            led_d = writeData[7:0];
        end
    end

    // TX framing FSM; uart_tx is registered from the next state so it lines up with the state
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shift_d = fifo_mem[rd_ptr_q];
                    bit_d   = 3'd0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                baud_d = baud_last ? '0 : baud_q + CW'(1);
                if (baud_last) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_d = baud_last ? '0 : baud_q + CW'(1);
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_last ? '0 : baud_q + CW'(1);
                if (baud_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            led_q    <= led_d;
        end
    end

    // Combinational load path
    always_comb begin
        readData = '0;
        if (sel_ram) begin
            readData = ram_mem[ram_idx];
        end else if (sel_status) begin
            readData = {16'b0, count8, 5'b0, ovf_q, fifo_full, busy};
        end else if (sel_led) begin
            readData = {24'b0, led_q};
        end
    end

    assign uart_tx = tx_q;
    assign led     = led_q;

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus: reset, RAM, UART framing, FIFO overflow, LED, mid-frame reset.
// Runs with CLKS_PER_BIT=4 and FIFO_DEPTH=8; inputs change 1 time unit after the rising edge.
// Outputs are sampled at least 1 time unit after the edge, never on it.
module tb_data_bus;

    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_LED    = 32'h8000_0008;
    localparam logic [31:0] A_UNMAP  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] dataAddr = '0;
    logic [31:0] writeData = '0;
    logic        we = 1'b0;
    logic [31:0] readData;
    logic        uart_tx;
    logic [7:0]  led;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    data_bus #(.RAM_WORDS(256), .FIFO_DEPTH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .n_reset(n_reset), .dataAddr(dataAddr), .writeData(writeData),
        .we(we), .readData(readData), .uart_tx(uart_tx), .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dataAddr = a; writeData = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset;
        n_reset = 1'b0; we = 1'b0;
        tick(); tick();
        n_reset = 1'b1; dataAddr = A_STATUS; #1;
        tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        tests++; if (led !== 8'h00) begin fails++; $display("FAIL reset_led: got %h want 00", led); end
        tests++; if (readData !== 32'h0) begin fails++; $display("FAIL reset_status: got %h want 00000000", readData); end
    endtask

    task automatic test_ram;
        wr(32'h0, 32'h1111_1111);
        dataAddr = 32'h0; writeData = 32'h0000_01FE; we = 1'b1; #1;
        tests++; if (readData !== 32'h1111_1111) begin fails++; $display("FAIL ram_same_cycle: got %h want 11111111", readData); end
        tick(); we = 1'b0; #1;
        tests++; if (readData !== 32'h0000_01FE) begin fails++; $display("FAIL ram_rd0: got %h want 000001fe", readData); end
        dataAddr = 32'h3; #1;
        tests++; if (readData !== 32'h0000_01FE) begin fails++; $display("FAIL ram_rd3: got %h want 000001fe", readData); end
        wr(32'h4, 32'hABCD_EF01);
        dataAddr = 32'h0; #1;
        tests++; if (readData !== 32'h0000_01FE) begin fails++; $display("FAIL ram_rd0_kept: got %h want 000001fe", readData); end
        dataAddr = 32'h4; #1;
        tests++; if (readData !== 32'hABCD_EF01) begin fails++; $display("FAIL ram_rd4: got %h want abcdef01", readData); end
        dataAddr = 32'h404; #1;
        tests++; if (readData !== 32'hABCD_EF01) begin fails++; $display("FAIL ram_alias: got %h want abcdef01", readData); end
    endtask

    task automatic test_uart_byte;
        logic [7:0] d;
        logic       exp_tx;
        int         bad_tx;
        int         bad_busy;
        d = 8'h55; bad_tx = 0; bad_busy = 0;
        dataAddr = A_TX; writeData = 32'h55; we = 1'b1; #1;
        tests++; if (readData !== 32'h0) begin fails++; $display("FAIL txdata_read: got %h want 00000000", readData); end
        tick();
        we = 1'b0; dataAddr = A_STATUS; #1;
        tests++; if (readData !== 32'h0000_0101) begin fails++; $display("FAIL status_after_push: got %h want 00000101", readData); end
        tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL tx_idle_k1: got %b want 1", uart_tx); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i / 4 == 0)      exp_tx = 1'b0;
            else if (i / 4 == 9) exp_tx = 1'b1;
            else                 exp_tx = d[i / 4 - 1];
            if (uart_tx !== exp_tx) bad_tx++;
            if (readData[0] !== 1'b1) bad_busy++;
        end
        tests++; if (bad_tx != 0) begin fails++; $display("FAIL frame_55: %0d cycles wrong, want 0", bad_tx); end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL busy_window: %0d cycles not busy, want 0", bad_busy); end
        tick();
        tests++; if (readData !== 32'h0) begin fails++; $display("FAIL busy_clear_k42: got %h want 00000000", readData); end
    endtask

    task automatic test_overflow_stream;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    dataAddr = A_TX; writeData = 32'(i); we = 1'b1;
                    tick();
                end
                we = 1'b0; dataAddr = A_STATUS; #1;
                tests++; if (readData !== 32'h0000_0807) begin fails++; $display("FAIL status_overflow: got %h want 00000807", readData); end
                writeData = 32'h0; we = 1'b1;
                tick();
                we = 1'b0; #1;
                tests++; if (readData !== 32'h0000_0803) begin fails++; $display("FAIL status_ovf_clear: got %h want 00000803", readData); end
            end
            begin
                int   s;
                int   prev_s;
                bit   found;
                logic [7:0] got;
                prev_s = 0;
                for (int n = 0; n < 9; n++) begin
                    found = 1'b0;
                    for (int w = 0; w < 100 && !found; w++) begin
                        if (uart_tx === 1'b0) found = 1'b1;
                        else tick();
                    end
                    s = cyc;
                    tests++; if (!found) begin fails++; $display("FAIL rx_start_%0d: no start bit, want one within 100 cycles", n); end
                    repeat (2) tick();
                    for (int b = 0; b < 8; b++) begin
                        repeat (4) tick();
                        got[b] = uart_tx;
                    end
                    repeat (4) tick();
                    tests++; if (got !== 8'(n)) begin fails++; $display("FAIL rx_byte_%0d: got %h want %h", n, got, 8'(n)); end
                    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL rx_stop_%0d: got %b want 1", n, uart_tx); end
                    if (n > 0) begin
                        tests++; if (s - prev_s != 41) begin fails++; $display("FAIL frame_period_%0d: got %0d want 41", n, s - prev_s); end
                    end
                    prev_s = s;
                end
            end
        join
        dataAddr = A_STATUS; #1;
        for (int w = 0; w < 50 && readData[0] !== 1'b0; w++) tick();
        tests++; if (readData !== 32'h0) begin fails++; $display("FAIL status_drained: got %h want 00000000", readData); end
    endtask

    task automatic test_led;
        wr(A_LED, 32'h0000_00A5);
        tests++; if (led !== 8'hA5) begin fails++; $display("FAIL led_pin: got %h want a5", led); end
        dataAddr = A_LED; #1;
        tests++; if (readData !== 32'h0000_00A5) begin fails++; $display("FAIL led_read: got %h want 000000a5", readData); end
        dataAddr = A_UNMAP; #1;
        tests++; if (readData !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h want 00000000", readData); end
        wr(A_UNMAP, 32'h0000_005A);
        tests++; if (led !== 8'hA5) begin fails++; $display("FAIL unmapped_write: led %h want a5", led); end
    endtask

    task automatic test_reset_midframe;
        int bad;
        bad = 0;
        wr(A_TX, 32'hA1); wr(A_TX, 32'hA2); wr(A_TX, 32'hA3); wr(A_TX, 32'hA4);
        repeat (6) tick();
        dataAddr = A_STATUS; #1;
        tests++; if (readData !== 32'h0000_0301) begin fails++; $display("FAIL status_pre_reset: got %h want 00000301", readData); end
        n_reset = 1'b0; dataAddr = A_LED; writeData = 32'hFF; we = 1'b1;
        tick();
        n_reset = 1'b1; we = 1'b0; dataAddr = A_STATUS; #1;
        tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL midreset_tx: got %b want 1", uart_tx); end
        tests++; if (readData !== 32'h0) begin fails++; $display("FAIL midreset_status: got %h want 00000000", readData); end
        tests++; if (led !== 8'h00) begin fails++; $display("FAIL midreset_led: got %h want 00", led); end
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_tx !== 1'b1) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL midreset_quiet: %0d low cycles want 0", bad); end
        dataAddr = 32'h0; #1;
        tests++; if (readData !== 32'h0000_01FE) begin fails++; $display("FAIL midreset_ram0: got %h want 000001fe", readData); end
        dataAddr = 32'h4; #1;
        tests++; if (readData !== 32'hABCD_EF01) begin fails++; $display("FAIL midreset_ram4: got %h want abcdef01", readData); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_uart_byte();
        test_overflow_stream();
        test_led();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
